// File: rtl/tictactoe_pkg.sv
// Shared types and codes for the tic-tac-toe game controller.
package tictactoe_pkg;

    localparam logic [1:0] VACIO = 2'b00;
    localparam logic [1:0] J1    = 2'b01;
    localparam logic [1:0] J2    = 2'b10;

    localparam logic [1:0] RES_NADA   = 2'b00;
    localparam logic [1:0] RES_J1     = 2'b01;
    localparam logic [1:0] RES_J2     = 2'b10;
    localparam logic [1:0] RES_EMPATE = 2'b11;

    typedef logic [8:0][1:0] tablero_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURNO = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } estado_t;

endpackage

// File: rtl/control_tablero_primera_libre.sv
// Priority encoder: lowest-index empty cell of the board plus an any-empty flag.
module primera_libre
    import tictactoe_pkg::*;
(
    input  tablero_t     tablero_i,
    output logic [3:0]   idx_o,
    output logic         hay_vacia_o
);

    always_comb begin
        idx_o       = 4'd0;
        hay_vacia_o = 1'b0;
        // Scan downward so the lowest empty index is the last one written.
        for (int i = 8; i >= 0; i--) begin
            if (tablero_i[i] == VACIO) begin
                idx_o       = 4'(i);
                hay_vacia_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_tablero.sv
// Tic-tac-toe game controller: owns the board, alternates turns, applies a
// per-turn time limit and declares win/draw using the external winner flag.
//
//   state | meaning
//   IDLE  | after reset, waiting for start; moves ignored
//   TURNO | waiting for a move from jugador; turn counter running
//   CHECK | one cycle to evaluate ganador / full board on the updated matriz
//   FIN   | game over; result held until the next start
module control_tablero
    import tictactoe_pkg::*;
#(
    parameter int TURN_CYCLES = 500_000_000,
    parameter int CNT_W       = $clog2(TURN_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mov_valid,
    input  logic [3:0]       mov_idx,
    input  logic             ganador,
    output logic [8:0][1:0]  matriz,
    output logic [1:0]       jugador,
    output logic             fin,
    output logic [1:0]       resultado,
    output logic             mov_error,
    output logic             timeout
);

    estado_t          estado_q, estado_d;
    tablero_t         matriz_q, matriz_d;
    logic [1:0]       jugador_q, jugador_d;
    logic [1:0]       resultado_q, resultado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mov_error_q, mov_error_d;
    logic             timeout_q, timeout_d;

    logic [3:0]       idx_libre;
    logic             hay_vacia;
    logic [1:0]       celda_sel;
    logic             idx_ok;
    logic             mov_legal;
    logic             expira;

    primera_libre u_primera_libre (
        .tablero_i   (matriz_q),
        .idx_o       (idx_libre),
        .hay_vacia_o (hay_vacia)
    );

    always_comb begin
        celda_sel = J1;
        for (int i = 0; i < 9; i++) begin
            if (mov_idx == 4'(i)) celda_sel = matriz_q[i];
        end
    end

    assign idx_ok    = (mov_idx <= 4'd8);
    assign mov_legal = mov_valid && idx_ok && (celda_sel == VACIO);
    assign expira    = (cnt_q == CNT_W'(TURN_CYCLES - 1));

    always_comb begin
        estado_d    = estado_q;
        matriz_d    = matriz_q;
        jugador_d   = jugador_q;
        resultado_d = resultado_q;
        cnt_d       = cnt_q;
        mov_error_d = 1'b0;
        timeout_d   = 1'b0;

        unique case (estado_q)
            IDLE, FIN: begin
                if (start) begin
                    estado_d    = TURNO;
                    matriz_d    = '0;
                    jugador_d   = J1;
                    resultado_d = RES_NADA;
                    cnt_d       = '0;
                end
            end
            TURNO: begin
                if (mov_legal) begin
                    for (int i = 0; i < 9; i++) begin
                        if (mov_idx == 4'(i)) matriz_d[i] = jugador_q;
                    end
                    cnt_d    = '0;
                    estado_d = CHECK;
                end else if (expira) begin
                    // Expiry outranks a rejected move so error and timeout never coincide.
                    for (int i = 0; i < 9; i++) begin
                        if (idx_libre == 4'(i)) matriz_d[i] = jugador_q;
                    end
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    estado_d  = CHECK;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    mov_error_d = mov_valid;
                end
            end
            CHECK: begin
                if (ganador) begin
                    estado_d    = FIN;
                    resultado_d = jugador_q;
                end else if (!hay_vacia) begin
                    estado_d    = FIN;
                    resultado_d = RES_EMPATE;
                end else begin
                    estado_d  = TURNO;
                    jugador_d = (jugador_q == J1) ? J2 : J1;
                    cnt_d     = '0;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= IDLE;
            matriz_q    <= '0;
            jugador_q   <= J1;
            resultado_q <= RES_NADA;
            cnt_q       <= '0;
            mov_error_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            matriz_q    <= matriz_d;
            jugador_q   <= jugador_d;
            resultado_q <= resultado_d;
            cnt_q       <= cnt_d;
            mov_error_q <= mov_error_d;
            timeout_q   <= timeout_d;
        end
    end

    assign matriz    = matriz_q;
    assign jugador   = jugador_q;
    assign fin       = (estado_q == FIN);
    assign resultado = resultado_q;
    assign mov_error = mov_error_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_control_tablero.sv
// Directed bench for control_tablero with a behavioural winner detector on matriz.
module tb_control_tablero;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             mov_valid = 1'b0;
    logic [3:0]       mov_idx = 4'd0;
    logic             ganador;
    logic [8:0][1:0]  matriz;
    logic [1:0]       jugador;
    logic             fin;
    logic [1:0]       resultado;
    logic             mov_error;
    logic             timeout;

    int total = 0;
    int bad   = 0;

    control_tablero #(.TURN_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mov_valid (mov_valid),
        .mov_idx   (mov_idx),
        .ganador   (ganador),
        .matriz    (matriz),
        .jugador   (jugador),
        .fin       (fin),
        .resultado (resultado),
        .mov_error (mov_error),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic tres(input logic [8:0][1:0] b, input int x, input int y, input int z);
        return (b[x] != 2'b00) && (b[x] == b[y]) && (b[y] == b[z]);
    endfunction

    always_comb begin
        ganador = tres(matriz, 0, 1, 2) | tres(matriz, 3, 4, 5) | tres(matriz, 6, 7, 8) |
                  tres(matriz, 0, 3, 6) | tres(matriz, 1, 4, 7) | tres(matriz, 2, 5, 8) |
                  tres(matriz, 0, 4, 8) | tres(matriz, 2, 4, 6);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; mov_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic mover(input int idx);
        mov_valid = 1'b1; mov_idx = 4'(idx);
        tick();
        mov_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (matriz !== '0) begin bad++; $display("FAIL reset_matriz got=%h exp=0", matriz); end
        total++; if (jugador !== 2'b01) begin bad++; $display("FAIL reset_jugador got=%b exp=01", jugador); end
        total++; if ({fin, resultado, mov_error, timeout} !== 5'b0) begin bad++;
            $display("FAIL reset_flags got=%b exp=00000", {fin, resultado, mov_error, timeout}); end
    endtask

    task automatic test_win_p1();
        logic [8:0][1:0] exp;
        do_reset();
        do_start();
        mov_valid = 1'b1; mov_idx = 4'd0;
        tick();
        mov_valid = 1'b0;
        total++; if (matriz[0] !== 2'b01 || jugador !== 2'b01) begin bad++;
            $display("FAIL latency_edgeN got cell0=%b jug=%b exp cell0=01 jug=01", matriz[0], jugador); end
        tick();
        total++; if (jugador !== 2'b10) begin bad++; $display("FAIL latency_edgeN1 jugador got=%b exp=10", jugador); end
        mover(3); mover(1); mover(4); mover(2);
        exp = '0; exp[0] = 2'b01; exp[1] = 2'b01; exp[2] = 2'b01; exp[3] = 2'b10; exp[4] = 2'b10;
        total++; if (fin !== 1'b1 || resultado !== 2'b01) begin bad++;
            $display("FAIL win_p1 got fin=%b res=%b exp fin=1 res=01", fin, resultado); end
        total++; if (matriz !== exp) begin bad++; $display("FAIL win_p1_board got=%h exp=%h", matriz, exp); end
    endtask

    task automatic test_illegal();
        logic [8:0][1:0] exp;
        do_reset();
        do_start();
        mover(4);
        exp = '0; exp[4] = 2'b01;
        for (int k = 0; k < 2; k++) begin
            mov_valid = 1'b1; mov_idx = (k == 0) ? 4'd4 : 4'd9;
            tick();
            mov_valid = 1'b0;
            total++; if (mov_error !== 1'b1) begin bad++; $display("FAIL illegal_err%0d got=%b exp=1", k, mov_error); end
            tick();
            total++; if (mov_error !== 1'b0) begin bad++; $display("FAIL illegal_pulse%0d got=%b exp=0", k, mov_error); end
            total++; if (matriz !== exp || jugador !== 2'b10 || fin !== 1'b0) begin bad++;
                $display("FAIL illegal_hold%0d got board=%h jug=%b fin=%b exp board=%h jug=10 fin=0", k, matriz, jugador, fin, exp); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        do_start();
        mover(0);
        for (int k = 0; k < 7; k++) tick();
        total++; if (timeout !== 1'b0 || matriz[1] !== 2'b00) begin bad++;
            $display("FAIL timeout_early got to=%b cell1=%b exp to=0 cell1=00", timeout, matriz[1]); end
        tick();
        total++; if (timeout !== 1'b1 || matriz[1] !== 2'b10) begin bad++;
            $display("FAIL timeout_fire got to=%b cell1=%b exp to=1 cell1=10", timeout, matriz[1]); end
        tick();
        total++; if (timeout !== 1'b0 || jugador !== 2'b01) begin bad++;
            $display("FAIL timeout_after got to=%b jug=%b exp to=0 jug=01", timeout, jugador); end
        for (int k = 0; k < 7; k++) tick();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_restart_early got=%b exp=0", timeout); end
        tick();
        total++; if (timeout !== 1'b1 || matriz[2] !== 2'b01) begin bad++;
            $display("FAIL timeout_restart got to=%b cell2=%b exp to=1 cell2=01", timeout, matriz[2]); end
    endtask

    task automatic test_draw();
        int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        do_reset();
        do_start();
        for (int k = 0; k < 9; k++) mover(seq[k]);
        total++; if (fin !== 1'b1 || resultado !== 2'b11) begin bad++;
            $display("FAIL draw got fin=%b res=%b exp fin=1 res=11", fin, resultado); end
        mov_valid = 1'b1; mov_idx = 4'd9;
        tick();
        mov_valid = 1'b0;
        total++; if (mov_error !== 1'b0 || fin !== 1'b1 || resultado !== 2'b11) begin bad++;
            $display("FAIL fin_hold got err=%b fin=%b res=%b exp err=0 fin=1 res=11", mov_error, fin, resultado); end
        do_start();
        total++; if (fin !== 1'b0 || resultado !== 2'b00 || matriz !== '0 || jugador !== 2'b01) begin bad++;
            $display("FAIL restart got fin=%b res=%b board=%h jug=%b exp fin=0 res=00 board=0 jug=01", fin, resultado, matriz, jugador); end
    endtask

    task automatic test_move_at_expiry();
        do_reset();
        do_start();
        mover(0);
        for (int k = 0; k < 7; k++) tick();
        mov_valid = 1'b1; mov_idx = 4'd5;
        tick();
        mov_valid = 1'b0;
        total++; if (matriz[5] !== 2'b10 || matriz[1] !== 2'b00 || timeout !== 1'b0) begin bad++;
            $display("FAIL move_vs_expiry got cell5=%b cell1=%b to=%b exp cell5=10 cell1=00 to=0", matriz[5], matriz[1], timeout); end
        tick();
        total++; if (timeout !== 1'b0 || jugador !== 2'b01) begin bad++;
            $display("FAIL move_vs_expiry_after got to=%b jug=%b exp to=0 jug=01", timeout, jugador); end
    endtask

    task automatic test_reset_midgame();
        do_reset();
        do_start();
        mover(0); mover(1); mover(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (matriz !== '0 || jugador !== 2'b01 || {fin, resultado, mov_error, timeout} !== 5'b0) begin bad++;
            $display("FAIL mid_reset got board=%h jug=%b flags=%b exp board=0 jug=01 flags=0", matriz, jugador, {fin, resultado, mov_error, timeout}); end
        mover(4);
        total++; if (matriz !== '0 || mov_error !== 1'b0) begin bad++;
            $display("FAIL idle_ignore got board=%h err=%b exp board=0 err=0", matriz, mov_error); end
        do_start();
        mover(4);
        total++; if (matriz[4] !== 2'b01 || jugador !== 2'b10) begin bad++;
            $display("FAIL after_start got cell4=%b jug=%b exp cell4=01 jug=10", matriz[4], jugador); end
    endtask

    initial begin
        test_reset();
        test_win_p1();
        test_illegal();
        test_timeout();
        test_draw();
        test_move_at_expiry();
        test_reset_midgame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
